multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I subset datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state enables to the shared ALU, register file, PC and unified memory port.
- It supports memory wait states via a ready handshake, a memory-timeout trap, an ecall halt/display path, and a retired-instruction counter.
- It sits between the instruction register (opcode source) and the datapath muxes and enables.

Parameters:
- CNT_W, 32: width of the instret counter.
- TIMEOUT, 16: maximum cycles to wait for mem_ready before trapping (range 1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  5  instruction bits [6:2]; valid from DECODE onward.
- halt_req  in  1  datapath flag (a7==10) sampled in EXEC of SYSTEM.
- br_taken  in  1  branch comparison result, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- resume  in  1  leaves HALT.
- mem_read  out  1  memory read request (fetch or load).
- mem_write  out  1  memory write request (store).
- ir_write  out  1  latch instruction register and old_pc.
- pc_write  out  1  PC load enable.
- pc_src  out  2  0=pc+4, 1=branch target, 2=jal target, 3=jalr target.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  0=ALU, 1=memory data, 2=pc+4 (from old_pc).
- alu_src_b  out  1  1=immediate, 0=rs2.
- ecall_show  out  1  one-cycle display strobe.
- halted  out  1  in HALT or TRAP.
- trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode classes: R=01100, I_ALU=00100, LOAD=00000, STORE=01000, BRANCH=11000, JAL=11011, JALR=11001, SYSTEM=11100. Any other value is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Reset: state=IDLE, instret=0, trap_cause=0, wait counter=0. All outputs are 0 while in IDLE.
- The next clock after reset moves IDLE->FETCH unconditionally. An rst_n assertion at any point, including mid-access, returns the FSM to IDLE immediately.
- Outputs are Moore/Mealy decoded from the state register. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle.
  - Illegal opcode -> TRAP with trap_cause=1.
  - Otherwise -> EXEC.
- EXEC: alu_src_b=1 for I_ALU/LOAD/STORE/JALR, otherwise 0.
  - R or I_ALU -> WB.
  - LOAD or STORE -> MEM.
  - BRANCH: pc_write=br_taken, pc_src=1, retire, -> FETCH.
  - JAL/JALR: pc_write=1, pc_src=2/3, reg_write=1, wb_sel=2, retire, -> FETCH.
  - SYSTEM with halt_req=1 -> HALT, retire.
  - SYSTEM with halt_req=0: ecall_show=1, retire, -> FETCH.
- MEM:
  - LOAD: mem_read=1 until mem_ready, then -> WB.
  - STORE: mem_write=1 until mem_ready; on the ready cycle retire and go -> FETCH.
  - The request is held stable while waiting.
- WB: reg_write=1, wb_sel=1 for LOAD else 0, retire, -> FETCH.
- Retire: instret+1 on the cycle stated above, wrapping modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH/MEM and on each mem_ready.
  - If it reaches TIMEOUT with no mem_ready: go to TRAP, trap_cause=2, drop the request, no retire.
  - mem_ready on the same cycle the count reaches TIMEOUT takes priority (the access completes).
- HALT: halted=1, no requests. resume=1 -> FETCH. trap_cause stays 0.
- TRAP: halted=1, sticky until reset. resume is ignored.
- Per-instruction latency with zero wait states: R/I/LOAD-less = 4 cycles (FETCH, DECODE, EXEC, WB); LOAD=5; STORE=4; BRANCH/JAL/JALR/SYSTEM=3.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - opcode class constants;
  - state encoding (3-bit);
  - pc_src, wb_sel and trap_cause encodings.
- One natural sub-module, opclass_decode: combinational opcode -> one-hot class plus illegal flag.
- The FSM, wait counter and instret remain in multicycle_sequencer.

Test Plan:
- Reset then R-type (opcode 01100), mem_ready always 1 -> IDLE, FETCH (ir_write=1, pc_write=1), DECODE, EXEC, WB (reg_write=1, wb_sel=0); instret=1 after 5 clocks.
- LOAD with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles; WB wb_sel=1; instret+1 only at WB.
- BRANCH with br_taken=0 then 1 -> pc_write=0 then 1 with pc_src=1 in EXEC; both retire (instret +2).
- SYSTEM with halt_req=0 -> ecall_show one cycle, back to FETCH. With halt_req=1 -> halted=1 until resume, then FETCH.
- Opcode 11111 -> TRAP with trap_cause=1. mem_ready held low 16 cycles in FETCH -> trap_cause=2. Both are sticky under resume, and rst_n clears them.
- rst_n pulsed low mid-store (mem_write=1) -> mem_write drops asynchronously, instret=0, restart from IDLE; also instret wrap with CNT_W=4 after 16 retires -> 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
package riscv_ctrl_pkg;

  // Instruction bits [6:2] of each supported opcode class
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I_ALU  = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  // One-hot opcode class
  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic system;
  } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode -> one-hot class decode with illegal-opcode flag.
module opclass_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output opclass_t   o_class,
  output logic       o_illegal
);

  // Exact-match each class; anything unmatched is illegal
  always_comb begin
    o_class        = '0;
    o_class.r      = (i_opcode == OP_R);
    o_class.i_alu  = (i_opcode == OP_I_ALU);
    o_class.load   = (i_opcode == OP_LOAD);
    o_class.store  = (i_opcode == OP_STORE);
    o_class.branch = (i_opcode == OP_BRANCH);
    o_class.jal    = (i_opcode == OP_JAL);
    o_class.jalr   = (i_opcode == OP_JALR);
    o_class.system = (i_opcode == OP_SYSTEM);
    o_illegal      = ~(|o_class);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait-state
// timeout trap, ecall halt/display and retired-instruction counter.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic             halt_req,
  input  logic             br_taken,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic             ecall_show,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  // Wait count value on the last permitted waiting cycle
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       r_trap_cause;
  opclass_t         w_class;
  logic             w_illegal;
  logic             w_retire;
  logic             w_trap_set;
  logic [1:0]       w_trap_val;

  opclass_decode u_opclass_decode (
    .i_opcode  (opcode),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  // Next-state and per-state datapath enables
  always_comb begin
    w_next     = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    alu_src_b  = 1'b0;
    ecall_show = 1'b0;
    halted     = 1'b0;
    w_retire   = 1'b0;
    w_trap_set = 1'b0;
    w_trap_val = TRAP_NONE;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_next     = S_TRAP;
          w_trap_set = 1'b1;
          w_trap_val = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_next     = S_TRAP;
          w_trap_set = 1'b1;
          w_trap_val = TRAP_ILLEGAL;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_b = w_class.i_alu | w_class.load | w_class.store | w_class.jalr;
        if (w_class.r || w_class.i_alu) begin
          w_next = S_WB;
        end else if (w_class.load || w_class.store) begin
          w_next = S_MEM;
        end else if (w_class.branch) begin
          pc_write = br_taken;
          pc_src   = PC_BRANCH;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_class.jal || w_class.jalr) begin
          pc_write  = 1'b1;
          pc_src    = w_class.jal ? PC_JAL : PC_JALR;
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end else if (w_class.system) begin
          w_retire = 1'b1;
          if (halt_req) begin
            w_next = S_HALT;
          end else begin
            ecall_show = 1'b1;
            w_next     = S_FETCH;
          end
        end else begin
          // Opcode changed under us after DECODE: treat as illegal
          w_next     = S_TRAP;
          w_trap_set = 1'b1;
          w_trap_val = TRAP_ILLEGAL;
        end
      end
      S_MEM: begin
        mem_write = w_class.store;
        mem_read  = ~w_class.store;
        if (mem_ready) begin
          if (w_class.store) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next     = S_TRAP;
          w_trap_set = 1'b1;
          w_trap_val = TRAP_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = w_class.load ? WB_MEM : WB_ALU;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) w_next = S_FETCH;
      end
      S_TRAP: halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Wait counter: counts unanswered cycles in FETCH/MEM, else held at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) &&
                 w_next == r_state && !mem_ready) begin
      r_wait <= r_wait + 8'd1;
    end else begin
      r_wait <= '0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 1'b1;
  end

  // Trap cause, sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_trap_cause <= TRAP_NONE;
    else if (w_trap_set) r_trap_cause <= w_trap_val;
  end

  assign trap_cause = r_trap_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [4:0] R_OP   = 5'b01100;
  localparam logic [4:0] LD_OP  = 5'b00000;
  localparam logic [4:0] ST_OP  = 5'b01000;
  localparam logic [4:0] BR_OP  = 5'b11000;
  localparam logic [4:0] JAL_OP = 5'b11011;
  localparam logic [4:0] SYS_OP = 5'b11100;
  localparam logic [4:0] BAD_OP = 5'b11111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       opcode;
  logic             halt_req, br_taken, mem_ready, resume;
  logic             mem_read, mem_write, ir_write, pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             alu_src_b, ecall_show, halted;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  int checks   = 0;
  int failures = 0;

  multicycle_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .halt_req   (halt_req),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
    .resume     (resume),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_b  (alu_src_b),
    .ecall_show (ecall_show),
    .halted     (halted),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; opcode = R_OP; halt_req = 1'b0; br_taken = 1'b0;
    mem_ready = 1'b1; resume = 1'b0;
    #12;
    check("idle_mem_read", mem_read, 0);
    check("idle_halted", halted, 0);
    check("idle_instret", instret, 0);
    check("idle_trap", trap_cause, 0);
    rst_n = 1'b1;

    // R-type, zero wait states
    cyc();
    check("r_fetch_rd", mem_read, 1);
    check("r_fetch_ir", ir_write, 1);
    check("r_fetch_pcw", pc_write, 1);
    check("r_fetch_pcsrc", pc_src, 0);
    cyc();
    check("r_dec_rd", mem_read, 0);
    check("r_dec_ir", ir_write, 0);
    cyc();
    check("r_exec_alub", alu_src_b, 0);
    check("r_exec_regw", reg_write, 0);
    cyc();
    check("r_wb_regw", reg_write, 1);
    check("r_wb_sel", wb_sel, 0);
    check("r_wb_instret", instret, 0);
    cyc();
    check("r_instret", instret, 1);
    check("r_back_fetch", mem_read, 1);

    // LOAD with three wait states in MEM
    opcode = LD_OP;
    cyc();
    cyc();
    check("ld_exec_alub", alu_src_b, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ld_mem_wait_rd", mem_read, 1);
    end
    mem_ready = 1'b1;
    #1;
    check("ld_mem_ready_rd", mem_read, 1);
    check("ld_mem_instret", instret, 1);
    cyc();
    check("ld_wb_regw", reg_write, 1);
    check("ld_wb_sel", wb_sel, 1);
    check("ld_wb_rd", mem_read, 0);
    check("ld_wb_instret", instret, 1);
    cyc();
    check("ld_instret", instret, 2);

    // BRANCH not taken then taken
    opcode = BR_OP; br_taken = 1'b0;
    cyc(); cyc();
    check("br0_pcw", pc_write, 0);
    check("br0_pcsrc", pc_src, 1);
    cyc();
    check("br0_instret", instret, 3);
    br_taken = 1'b1;
    cyc(); cyc();
    check("br1_pcw", pc_write, 1);
    check("br1_pcsrc", pc_src, 1);
    cyc();
    check("br1_instret", instret, 4);
    br_taken = 1'b0;

    // JAL
    opcode = JAL_OP;
    cyc(); cyc();
    check("jal_pcsrc", pc_src, 2);
    check("jal_regw", reg_write, 1);
    check("jal_wbsel", wb_sel, 2);
    cyc();
    check("jal_instret", instret, 5);

    // STORE, zero wait
    opcode = ST_OP;
    cyc(); cyc();
    check("st_exec_alub", alu_src_b, 1);
    cyc();
    check("st_mem_wr", mem_write, 1);
    check("st_mem_rd", mem_read, 0);
    cyc();
    check("st_instret", instret, 6);

    // SYSTEM display then halt
    opcode = SYS_OP; halt_req = 1'b0;
    cyc(); cyc();
    check("ecall_show", ecall_show, 1);
    cyc();
    check("ecall_show_drop", ecall_show, 0);
    check("ecall_instret", instret, 7);
    halt_req = 1'b1;
    cyc(); cyc();
    check("halt_exec_show", ecall_show, 0);
    cyc();
    check("halt_halted", halted, 1);
    check("halt_rd", mem_read, 0);
    check("halt_instret", instret, 8);
    check("halt_trap", trap_cause, 0);
    cyc();
    check("halt_stays", halted, 1);
    resume = 1'b1;
    cyc();
    resume = 1'b0; halt_req = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_fetch", mem_read, 1);

    // Eight more R-types wrap the 4-bit counter from 8 to 0
    opcode = R_OP;
    for (int i = 0; i < 8; i++) begin
      cyc(); cyc(); cyc(); cyc();
    end
    check("instret_wrap", instret, 0);

    // Illegal opcode trap, sticky under resume
    opcode = BAD_OP;
    cyc(); cyc();
    check("ill_halted", halted, 1);
    check("ill_cause", trap_cause, 1);
    resume = 1'b1;
    cyc(); cyc();
    resume = 1'b0;
    check("ill_sticky_halted", halted, 1);
    check("ill_sticky_cause", trap_cause, 1);
    check("ill_sticky_rd", mem_read, 0);

    // Reset clears trap
    rst_n = 1'b0;
    #1;
    check("rst_trap", trap_cause, 0);
    check("rst_halted", halted, 0);
    #2;
    rst_n = 1'b1;
    cyc();

    // STORE whose ready arrives on the 16th waiting cycle completes
    opcode = ST_OP;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    check("st_last_wait_wr", mem_write, 1);
    mem_ready = 1'b1;
    cyc();
    check("st_last_halted", halted, 0);
    check("st_last_instret", instret, 1);

    // Asynchronous reset in the middle of a store
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    check("mid_st_wr", mem_write, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr", mem_write, 0);
    check("mid_rst_instret", instret, 0);
    #2;
    rst_n = 1'b1;
    cyc();
    check("mid_rst_fetch", mem_read, 1);

    // FETCH timeout: 16 cycles with no ready
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    check("to_last_rd", mem_read, 1);
    check("to_last_halted", halted, 0);
    cyc();
    check("to_halted", halted, 1);
    check("to_cause", trap_cause, 2);
    check("to_rd_drop", mem_read, 0);
    check("to_instret", instret, 0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check("to_sticky", trap_cause, 2);
    rst_n = 1'b0;
    #1;
    check("to_rst_cause", trap_cause, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
